data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
//
// Shares one single-ported data memory between the pipeline memory stage
// (p_ ports) and a debug/DMA master (d_ ports). Only one access is ever in
// flight: a request is accepted in IDLE, issued to the memory for one cycle,
// waits MEM_LATENCY cycles for read data, and is answered with a one-cycle
// response pulse to its owner. The pipeline normally has priority; the debug
// port is guaranteed service after STARVE_LIMIT consecutive lost arbitrations.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   p_req_valid/write/addr/wdata, p_req_ready   pipeline request handshake
//   p_rsp_valid, p_rdata      pipeline response pulse and read data
//   d_*                       debug/DMA port, same meaning as the p_ ports
//   mem_en, mem_we            memory access strobe / write enable
//   mem_addr, mem_wdata       memory address / write data
//   mem_rdata                 memory read data (valid MEM_LATENCY cycles after mem_en)
// ---------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p_req_valid,
    input  logic              p_req_write,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_req_ready,
    output logic              p_rsp_valid,
    output logic [DATA_W-1:0] p_rdata,

    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [3:0]        starveCnt;
    logic [3:0]        waitCnt;
    logic              pWin;
    logic              dWin;

    // Registered request (owner, direction, address, write data)
    logic              ownerDbg_p0;
    logic              write_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        pWin        = 1'b0;
        dWin        = 1'b0;
        p_req_ready = 1'b0;
        d_req_ready = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        p_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // A starved debug request overrides pipeline priority.
                dWin        = d_req_valid && ((starveCnt == LIMIT) || !p_req_valid);
                pWin        = p_req_valid && !dWin;
                p_req_ready = pWin;
                d_req_ready = dWin;
                if (pWin || dWin) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = write_p0;
                stateNext = WAIT;
            end
            WAIT: begin
                if (waitCnt == 4'd1) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                p_rsp_valid = !ownerDbg_p0;
                d_rsp_valid = ownerDbg_p0;
                stateNext   = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;

    // Starvation counter: counts consecutive cycles the waiting debug port
    // lost to the pipeline; frozen while an access is in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starveCnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!d_req_valid || dWin) begin
                starveCnt <= 4'd0;
            end else if (pWin && (starveCnt != LIMIT)) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end
    end

    // WAIT down-counter, loaded as the access leaves ISSUE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waitCnt <= 4'd0;
        end else if (state == ISSUE) begin
            waitCnt <= LATENCY;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt - 4'd1;
        end
    end

    // ---- stage p0: request capture at acceptance ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ownerDbg_p0 <= 1'b0;
            write_p0    <= 1'b0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
        end else if (pWin || dWin) begin
            ownerDbg_p0 <= dWin;
            write_p0    <= dWin ? d_req_write : p_req_write;
            addr_p0     <= dWin ? d_addr      : p_addr;
            wdata_p0    <= dWin ? d_wdata     : p_wdata;
        end
    end

    // ---- stage p1: response data capture in the last WAIT cycle ----
    // Each port's rdata only changes when that port owns the access, so it
    // holds its previous value at all other times. Writes return zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_rdata <= '0;
            d_rdata <= '0;
        end else if ((state == WAIT) && (waitCnt == 4'd1)) begin
            if (ownerDbg_p0) begin
                d_rdata <= write_p0 ? '0 : mem_rdata;
            end else begin
                p_rdata <= write_p0 ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p_req_valid = 1'b0, p_req_write = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        p_req_ready, p_rsp_valid;
    logic [31:0] p_rdata;
    logic        d_req_valid = 1'b0, d_req_write = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_req_ready, d_rsp_valid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int nPass   = 0;
    int nChecks = 0;

    data_memory_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)
    ) dut (
        .clock(clock), .reset(reset),
        .p_req_valid(p_req_valid), .p_req_write(p_req_write), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_req_ready(p_req_ready), .p_rsp_valid(p_rsp_valid),
        .p_rdata(p_rdata),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
        .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Default memory contents for locations never written.
    function automatic logic [31:0] initVal(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
    endfunction

    // Memory model with one cycle of read latency; writes return garbage on
    // the read bus so a write response of zero is meaningful.
    logic [31:0] mem [256];
    bit          wr  [256];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr[mem_addr[7:0]]  <= 1'b1;
                mem_rdata          <= 32'hBAD0BAD0;
            end else begin
                mem_rdata <= wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : initVal(mem_addr[7:0]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic setP(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        p_req_valid = v; p_req_write = w; p_addr = a; p_wdata = d;
    endtask

    task automatic setD(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        d_req_valid = v; d_req_write = w; d_addr = a; d_wdata = d;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Transaction-level reference model for the random phase
    typedef struct {
        int          t;
        bit          dbg;
        logic [31:0] data;
    } rsp_t;
    rsp_t        rspQ[$];
    rsp_t        r;
    logic [31:0] refMem [256];
    bit          pPend, dPend, pW, dW, eP, eD, free;
    logic [31:0] pA, pD, dA, dD;
    int          losses, nextFree, issueAt, nAcc;

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("rst p_ready", p_req_ready, 0);
        check("rst d_ready", d_req_ready, 0);
        check("rst mem_en", mem_en, 0);
        check("rst mem_we", mem_we, 0);
        check("rst p_rsp", p_rsp_valid, 0);
        check("rst d_rsp", d_rsp_valid, 0);
        check("rst p_rdata", p_rdata, 0);
        check("rst d_rdata", d_rdata, 0);
        check("rst mem_addr", mem_addr, 0);
        @(negedge clock);
        reset = 1'b1;
        nextCycle();

        // ---------------- pipeline read 0x10 ----------------
        setP(1, 0, 32'h10, 0);
        @(negedge clock);
        check("rd p_ready c0", p_req_ready, 1);
        check("rd d_ready c0", d_req_ready, 0);
        nextCycle();
        setP(0, 0, 0, 0);
        @(negedge clock);
        check("rd mem_en c1", mem_en, 1);
        check("rd mem_we c1", mem_we, 0);
        check("rd mem_addr c1", mem_addr, 32'h10);
        nextCycle();
        @(negedge clock);
        check("rd mem_en c2", mem_en, 0);
        check("rd p_rsp c2", p_rsp_valid, 0);
        nextCycle();
        @(negedge clock);
        check("rd p_rsp c3", p_rsp_valid, 1);
        check("rd p_rdata c3", p_rdata, 32'hDEADBEEF);
        check("rd d_rsp c3", d_rsp_valid, 0);
        nextCycle();
        @(negedge clock);
        check("rd p_rsp c4", p_rsp_valid, 0);
        check("rd p_rdata hold", p_rdata, 32'hDEADBEEF);
        nextCycle();

        // ---------------- debug write 0x20 <= 0x55 ----------------
        setD(1, 1, 32'h20, 32'h55);
        @(negedge clock);
        check("wr d_ready c0", d_req_ready, 1);
        check("wr p_ready c0", p_req_ready, 0);
        nextCycle();
        setD(0, 0, 0, 0);
        @(negedge clock);
        check("wr mem_en c1", mem_en, 1);
        check("wr mem_we c1", mem_we, 1);
        check("wr mem_addr c1", mem_addr, 32'h20);
        check("wr mem_wdata c1", mem_wdata, 32'h55);
        nextCycle();
        nextCycle();
        @(negedge clock);
        check("wr d_rsp c3", d_rsp_valid, 1);
        check("wr d_rdata c3", d_rdata, 0);
        check("wr p_rsp c3", p_rsp_valid, 0);
        nextCycle();

        // ---------------- simultaneous p and d ----------------
        setP(1, 0, 32'h10, 0);
        setD(1, 0, 32'h20, 0);
        @(negedge clock);
        check("both p_ready c0", p_req_ready, 1);
        check("both d_ready c0", d_req_ready, 0);
        nextCycle();
        setP(0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            check("both d_ready busy", d_req_ready, 0);
            nextCycle();
        end
        @(negedge clock);
        check("both d_ready c4", d_req_ready, 1);
        nextCycle();
        setD(0, 0, 0, 0);
        nextCycle();
        nextCycle();
        @(negedge clock);
        check("both d_rsp c7", d_rsp_valid, 1);
        check("both d_rdata c7", d_rdata, 32'h55);
        nextCycle();

        // ---------------- both held: starvation ----------------
        for (int k = 0; k <= 16; k++) begin
            if (k <= 12) begin
                setP(1, 0, 32'h10, 0);
                setD(1, 0, 32'h11, 0);
            end else begin
                setP(0, 0, 0, 0);
                setD(0, 0, 0, 0);
            end
            @(negedge clock);
            check($sformatf("starve p_ready k%0d", k), p_req_ready, (k == 0 || k == 4 || k == 12));
            check($sformatf("starve d_ready k%0d", k), d_req_ready, (k == 8));
            check($sformatf("starve p_rsp k%0d", k), p_rsp_valid, (k == 3 || k == 7 || k == 15));
            check($sformatf("starve d_rsp k%0d", k), d_rsp_valid, (k == 11));
            if (k == 11) check("starve d_rdata", d_rdata, initVal(8'h11));
            nextCycle();
        end

        // ---------------- back-to-back pipeline reads ----------------
        nAcc = 0;
        for (int k = 0; k <= 12; k++) begin
            setP(nAcc < 3, 0, 32'h30 + nAcc, 0);
            @(negedge clock);
            check($sformatf("b2b p_ready k%0d", k), p_req_ready, (k % 4 == 0 && k <= 8));
            check($sformatf("b2b p_rsp k%0d", k), p_rsp_valid, (k % 4 == 3 && k <= 11));
            if (k % 4 == 3) check($sformatf("b2b p_rdata k%0d", k), p_rdata, initVal(8'(8'h30 + k / 4)));
            nextCycle();
            if (k % 4 == 0 && k <= 8) nAcc++;
        end
        setP(0, 0, 0, 0);

        // ---------------- reset during WAIT ----------------
        setP(1, 0, 32'h40, 0);
        @(negedge clock);
        check("rstw p_ready c0", p_req_ready, 1);
        nextCycle();
        setP(0, 0, 0, 0);
        @(negedge clock);
        check("rstw mem_en c1", mem_en, 1);
        nextCycle();
        #2;
        reset = 1'b0;
        #1;
        check("rstw mem_en", mem_en, 0);
        check("rstw mem_we", mem_we, 0);
        check("rstw p_rsp", p_rsp_valid, 0);
        check("rstw d_rsp", d_rsp_valid, 0);
        check("rstw p_rdata", p_rdata, 0);
        check("rstw mem_addr", mem_addr, 0);
        @(negedge clock);
        check("rstw p_rsp neg", p_rsp_valid, 0);
        nextCycle();
        check("rstw p_rsp held", p_rsp_valid, 0);
        @(negedge clock);
        reset = 1'b1;
        setP(1, 0, 32'h10, 0);
        #1;
        check("rstw p_ready after", p_req_ready, 1);
        check("rstw p_rsp after", p_rsp_valid, 0);
        nextCycle();
        setP(0, 0, 0, 0);
        @(negedge clock);
        check("rstw mem_en new", mem_en, 1);
        check("rstw mem_addr new", mem_addr, 32'h10);
        check("rstw p_rsp new c1", p_rsp_valid, 0);
        nextCycle();
        @(negedge clock);
        check("rstw p_rsp new c2", p_rsp_valid, 0);
        nextCycle();
        @(negedge clock);
        check("rstw p_rsp new c3", p_rsp_valid, 1);
        check("rstw p_rdata new", p_rdata, 32'hDEADBEEF);
        nextCycle();

        // ---------------- randomized traffic vs. reference model ----------------
        for (int i = 0; i < 256; i++) refMem[i] = wr[i] ? mem[i] : initVal(8'(i));
        pPend = 0; dPend = 0; losses = 0; nextFree = 0; issueAt = -1;
        for (int c = 0; c < 400; c++) begin
            if (!pPend && $urandom_range(0, 2) == 0) begin
                pPend = 1; pW = 1'($urandom_range(0, 1));
                pA = 32'h80 + $urandom_range(0, 15); pD = $urandom;
            end
            if (!dPend && $urandom_range(0, 1) == 0) begin
                dPend = 1; dW = 1'($urandom_range(0, 1));
                dA = 32'h80 + $urandom_range(0, 15); dD = $urandom;
            end
            setP(pPend, pW, pA, pD);
            setD(dPend, dW, dA, dD);
            free = (c >= nextFree);
            eD = free && dPend && (losses == 2 || !pPend);
            eP = free && pPend && !eD;
            @(negedge clock);
            check("rnd p_ready", p_req_ready, eP);
            check("rnd d_ready", d_req_ready, eD);
            check("rnd mem_en", mem_en, (c == issueAt));
            if (rspQ.size() > 0 && rspQ[0].t == c) begin
                r = rspQ.pop_front();
                check("rnd p_rsp", p_rsp_valid, !r.dbg);
                check("rnd d_rsp", d_rsp_valid, r.dbg);
                check("rnd rdata", r.dbg ? d_rdata : p_rdata, r.data);
            end else begin
                check("rnd p_rsp idle", p_rsp_valid, 0);
                check("rnd d_rsp idle", d_rsp_valid, 0);
            end
            if (free) begin
                if (!dPend || eD) losses = 0;
                else if (eP && losses < 2) losses++;
            end
            if (eP || eD) begin
                r.t = c + 3;
                r.dbg = eD;
                if (eD) begin
                    r.data = dW ? 32'h0 : refMem[dA[7:0]];
                    if (dW) refMem[dA[7:0]] = dD;
                    dPend = 0;
                end else begin
                    r.data = pW ? 32'h0 : refMem[pA[7:0]];
                    if (pW) refMem[pA[7:0]] = pD;
                    pPend = 0;
                end
                rspQ.push_back(r);
                nextFree = c + 4;
                issueAt  = c + 1;
            end
            nextCycle();
        end
        setP(0, 0, 0, 0);
        setD(0, 0, 0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
